// File: rtl/decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_ctrl
// Description : IF->ID pipeline-register controller for a 5-stage RISC-V
//               core. Captures fetched instructions over a valid/ready
//               handshake, registers the immediate-type select alongside the
//               instruction, inserts a one-cycle bubble on a load-use hazard
//               against EX, honours redirect flushes and counts bubble cycles
//               in a saturating counter.
// Ports       :
//   clk          core clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   if_valid     fetch presents an instruction
//   if_instr     fetched instruction word
//   if_pc        PC of if_instr
//   if_ready     ID can accept an instruction this cycle
//   id_valid     ID instruction offered to EX
//   ex_ready     EX accepts the ID instruction this cycle
//   id_instr     registered instruction
//   id_pc        registered PC
//   id_imm_type  0=I 1=U 2=S 3=R 4=SB 5=UJ
//   id_illegal   opcode not in the supported set
//   ex_is_load   instruction currently in EX is a load
//   ex_rd        destination register of the EX instruction
//   flush        redirect: kill ID and the wrong-path fetch
//   stall_cnt    load-use bubble cycles, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_ready,
    output logic             id_valid,
    input  logic             ex_ready,
    output logic [31:0]      id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [2:0]       id_imm_type,
    output logic             id_illegal,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0]       c_imm_i     = 3'd0;
    localparam logic [2:0]       c_imm_u     = 3'd1;
    localparam logic [2:0]       c_imm_s     = 3'd2;
    localparam logic [2:0]       c_imm_r     = 3'd3;
    localparam logic [2:0]       c_imm_sb    = 3'd4;
    localparam logic [2:0]       c_imm_uj    = 3'd5;
    localparam logic [CNT_W-1:0] c_stall_max = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_HAZ   = 2'd2
    } state_t;

    state_t            r_state_q,    w_state_d;
    logic [31:0]       r_instr_q,    w_instr_d;
    logic [XLEN-1:0]   r_pc_q,       w_pc_d;
    logic [2:0]        r_imm_type_q, w_imm_type_d;
    logic              r_illegal_q,  w_illegal_d;
    logic [CNT_W-1:0]  r_stall_q,    w_stall_d;

    logic [2:0]        w_cap_type;
    logic              w_cap_ill;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_hazard;
    logic              w_id_valid;
    logic              w_fire;
    logic              w_capture;

    // Decode of the incoming word; result is registered together with it.
    always_comb begin
        w_cap_type = c_imm_r;
        w_cap_ill  = 1'b0;
        case (if_instr[6:0])
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b1110011: w_cap_type = c_imm_i;
            7'b0110111, 7'b0010111: w_cap_type = c_imm_u;
            7'b0100011:             w_cap_type = c_imm_s;
            7'b0110011:             w_cap_type = c_imm_r;
            7'b1100011:             w_cap_type = c_imm_sb;
            7'b1101111:             w_cap_type = c_imm_uj;
            default: begin
                w_cap_type = c_imm_r;
                w_cap_ill  = 1'b1;
            end
        endcase
    end

    // Source-register usage follows the registered format. An illegal word
    // reads nothing, so it can never cause a bubble even though its type
    // select reads back as R.
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        if (!r_illegal_q) begin
            case (r_imm_type_q)
                c_imm_i: w_use_rs1 = 1'b1;
                c_imm_s, c_imm_r, c_imm_sb: begin
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                end
                default: begin
                    w_use_rs1 = 1'b0;
                    w_use_rs2 = 1'b0;
                end
            endcase
        end
    end

    // Only checked in VALID: once the bubble has been issued the load has
    // moved on, so HAZ offers the instruction unconditionally.
    assign w_hazard = (r_state_q == ST_VALID) && ex_is_load && (ex_rd != 5'd0) &&
                      ((w_use_rs1 && (r_instr_q[19:15] == ex_rd)) ||
                       (w_use_rs2 && (r_instr_q[24:20] == ex_rd)));

    assign w_id_valid = ((r_state_q == ST_VALID) && !w_hazard) || (r_state_q == ST_HAZ);
    assign w_fire     = w_id_valid && ex_ready;

    // During a flush the fetch handshake is still accepted so the
    // wrong-path word drains out of fetch; it is simply never captured.
    assign if_ready   = rst_n && ((r_state_q == ST_EMPTY) || w_fire || flush);

    always_comb begin
        w_state_d = r_state_q;
        w_stall_d = r_stall_q;
        w_capture = 1'b0;
        if (flush) begin
            w_state_d = ST_EMPTY;
        end else begin
            case (r_state_q)
                ST_EMPTY: begin
                    if (if_valid) begin
                        w_capture = 1'b1;
                        w_state_d = ST_VALID;
                    end
                end
                ST_VALID, ST_HAZ: begin
                    if (w_hazard) begin
                        w_state_d = ST_HAZ;
                        if (r_stall_q != c_stall_max) begin
                            w_stall_d = r_stall_q + 1'b1;
                        end
                    end else if (w_fire) begin
                        if (if_valid) begin
                            w_capture = 1'b1;
                            w_state_d = ST_VALID;
                        end else begin
                            w_state_d = ST_EMPTY;
                        end
                    end
                end
                default: w_state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_instr_d    = r_instr_q;
        w_pc_d       = r_pc_q;
        w_imm_type_d = r_imm_type_q;
        w_illegal_d  = r_illegal_q;
        if (w_capture) begin
            w_instr_d    = if_instr;
            w_pc_d       = if_pc;
            w_imm_type_d = w_cap_type;
            w_illegal_d  = w_cap_ill;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q    <= ST_EMPTY;
            r_instr_q    <= 32'd0;
            r_pc_q       <= '0;
            r_imm_type_q <= c_imm_r;
            r_illegal_q  <= 1'b0;
            r_stall_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_instr_q    <= w_instr_d;
            r_pc_q       <= w_pc_d;
            r_imm_type_q <= w_imm_type_d;
            r_illegal_q  <= w_illegal_d;
            r_stall_q    <= w_stall_d;
        end
    end

    assign id_valid    = w_id_valid;
    assign id_instr    = r_instr_q;
    assign id_pc       = r_pc_q;
    assign id_imm_type = r_imm_type_q;
    assign id_illegal  = r_illegal_q;
    assign stall_cnt   = r_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_ctrl
// Description : Scoreboard bench for decode_stage_ctrl. Accepted fetches
//               push their hand-computed expected decode into a queue; a
//               monitor pops and compares whenever ID hands an instruction
//               to EX. Bubble, flush, back-pressure, reset and saturation
//               behaviour are checked directly against directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_ctrl;

    localparam int XLEN     = 32;
    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                if_valid;
    logic [31:0]         if_instr;
    logic [XLEN-1:0]     if_pc;
    logic                if_ready;
    logic                id_valid;
    logic                ex_ready;
    logic [31:0]         id_instr;
    logic [XLEN-1:0]     id_pc;
    logic [2:0]          id_imm_type;
    logic                id_illegal;
    logic                ex_is_load;
    logic [4:0]          ex_rd;
    logic                flush;
    logic [TB_CNT_W-1:0] stall_cnt;

    decode_stage_ctrl #(.XLEN(XLEN), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .id_valid(id_valid), .ex_ready(ex_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_imm_type(id_imm_type), .id_illegal(id_illegal),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  t;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [2:0]  cur_type = 3'd0;
    logic        cur_ill  = 1'b0;
    int          exp_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every ID->EX transfer, push on every accepted fetch.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (id_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got instr 0x%08h, expected none", id_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_instr",    id_instr,           e.instr);
                    chk("out_pc",       id_pc,              e.pc);
                    chk("out_imm_type", {29'd0, id_imm_type}, {29'd0, e.t});
                    chk("out_illegal",  {31'd0, id_illegal},  {31'd0, e.ill});
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (if_valid && if_ready) begin
                e.instr = if_instr;
                e.pc    = if_pc;
                e.t     = cur_type;
                e.ill   = cur_ill;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and waits (bounded) for it to be accepted.
    task automatic send_one(input logic [31:0] instr, input logic [31:0] pc,
                            input logic [2:0] t, input logic ill);
        bit ok = 1'b0;
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        cur_type = t;
        cur_ill  = ill;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (if_ready) ok = 1'b1;
            step();
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no if_ready, expected accept of 0x%08h", instr);
        end
        if_valid = 1'b0;
    endtask

    // Loads an instruction into ID, then presents an EX load and checks
    // whether a bubble is (or is not) inserted.
    task automatic do_hazard(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [2:0] t, input bit load,
                             input logic [4:0] rd, input bit bubble);
        send_one(instr, pc, t, 1'b0);
        ex_is_load = load;
        ex_rd      = rd;
        #1;
        chk("hz_id_valid", {31'd0, id_valid}, {31'd0, !bubble});
        chk("hz_if_ready", {31'd0, if_ready}, {31'd0, !bubble});
        if (bubble) begin
            exp_stall = (exp_stall == (1 << TB_CNT_W) - 1) ? exp_stall : exp_stall + 1;
            step();
            ex_is_load = 1'b0;
            chk("hz_after_valid", {31'd0, id_valid}, 32'd1);
            chk("hz_stall_cnt",   {28'd0, stall_cnt}, exp_stall);
            step();
        end else begin
            step();
            ex_is_load = 1'b0;
            chk("nohz_stall_cnt", {28'd0, stall_cnt}, exp_stall);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        if_valid   = 1'b1;
        if_instr   = 32'h00500093;
        if_pc      = 32'h0;
        ex_ready   = 1'b1;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        flush      = 1'b0;

        // Reset state; if_ready must stay low while reset is asserted.
        step();
        step();
        chk("rst_if_ready", {31'd0, if_ready},    32'd0);
        chk("rst_id_valid", {31'd0, id_valid},    32'd0);
        chk("rst_id_instr", id_instr,             32'd0);
        chk("rst_id_pc",    id_pc,                32'd0);
        chk("rst_imm_type", {29'd0, id_imm_type}, 32'd3);
        chk("rst_illegal",  {31'd0, id_illegal},  32'd0);
        chk("rst_stall",    {28'd0, stall_cnt},   32'd0);
        if_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        // addi at pc 0: visible on ID one cycle after the handshake.
        send_one(32'h00500093, 32'h0, 3'd0, 1'b0);
        chk("addi_id_valid", {31'd0, id_valid},    32'd1);
        chk("addi_imm_type", {29'd0, id_imm_type}, 32'd0);
        chk("addi_id_pc",    id_pc,                32'd0);
        step();

        // Load-use cases.
        do_hazard(32'h00308133, 32'h4,  3'd3, 1'b1, 5'd0, 1'b0); // rd=x0: no bubble
        do_hazard(32'h00308133, 32'h8,  3'd3, 1'b0, 5'd1, 1'b0); // not a load
        do_hazard(32'h00308133, 32'hC,  3'd3, 1'b1, 5'd1, 1'b1); // rs1 match
        do_hazard(32'h00308133, 32'h10, 3'd3, 1'b1, 5'd3, 1'b1); // rs2 match
        do_hazard(32'h123452B7, 32'h14, 3'd1, 1'b1, 5'd8, 1'b0); // U reads nothing
        do_hazard(32'h00500093, 32'h18, 3'd0, 1'b1, 5'd5, 1'b0); // I ignores rs2 field

        // Back-to-back stream of each format.
        send_one(32'h00112023, 32'h20, 3'd2, 1'b0); // sw
        send_one(32'h00208063, 32'h24, 3'd4, 1'b0); // beq
        send_one(32'h00000517, 32'h28, 3'd1, 1'b0); // auipc
        send_one(32'h0000A103, 32'h2C, 3'd0, 1'b0); // lw
        send_one(32'h00000073, 32'h30, 3'd0, 1'b0); // ecall
        send_one(32'h000080E7, 32'h34, 3'd0, 1'b0); // jalr
        step();

        // Flush while VALID with a fetch pending: the fetched word is dropped.
        send_one(32'h00500093, 32'h200, 3'd0, 1'b0);
        ex_ready = 1'b0;
        flush    = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h00308133;
        if_pc    = 32'h204;
        #1;
        chk("flush_if_ready", {31'd0, if_ready}, 32'd1);
        step();
        flush    = 1'b0;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        chk("flush_id_valid", {31'd0, id_valid},  32'd0);
        chk("flush_stall",    {28'd0, stall_cnt}, exp_stall);
        step();
        chk("flush_dropped",  {31'd0, id_valid},  32'd0);

        // Back-pressure with a stream of jal.
        send_one(32'h0000006F, 32'h100, 3'd5, 1'b0);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h0000006F;
        if_pc    = 32'h104;
        cur_type = 3'd5;
        cur_ill  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_instr", id_instr,             32'h0000006F);
            chk("bp_id_pc",    id_pc,                32'h100);
            chk("bp_if_ready", {31'd0, if_ready},    32'd0);
            chk("bp_imm_type", {29'd0, id_imm_type}, 32'd5);
            step();
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, if_ready}, 32'd1);
        step();
        if_valid = 1'b0;
        chk("bp_next_pc", id_pc, 32'h104);
        step();

        // Unsupported opcode.
        send_one(32'h0000007F, 32'h300, 3'd3, 1'b1);
        chk("ill_flag",     {31'd0, id_illegal},  32'd1);
        chk("ill_imm_type", {29'd0, id_imm_type}, 32'd3);
        step();

        // Drive the counter to its ceiling and beyond.
        for (int i = 0; i < 16; i++) begin
            do_hazard(32'h00308133, 32'h400 + i * 4, 3'd3, 1'b1, 5'd1, 1'b1);
        end
        chk("sat_stall", {28'd0, stall_cnt}, 32'd15);

        // Mid-operation reset.
        send_one(32'h00112023, 32'h500, 3'd2, 1'b0);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("mrst_if_ready", {31'd0, if_ready}, 32'd0);
        step();
        chk("mrst_id_valid", {31'd0, id_valid},    32'd0);
        chk("mrst_id_instr", id_instr,             32'd0);
        chk("mrst_imm_type", {29'd0, id_imm_type}, 32'd3);
        chk("mrst_stall",    {28'd0, stall_cnt},   32'd0);
        rst_n    = 1'b1;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        step();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
